// File: rtl/attitude_pkg.sv
// attitude_pkg
//   Shared definitions for the attitude encoder: bit positions inside the
//   4-bit attitude code, the level (both axes zero) code, the code type and
//   the persistence state record held by the commit stage.
package attitude_pkg;

  localparam int ATT_SGN_ROLL  = 0;
  localparam int ATT_SGN_PITCH = 1;
  localparam int ATT_Z_ROLL    = 2;
  localparam int ATT_Z_PITCH   = 3;

  typedef logic [3:0] attitude_code_t;

  localparam attitude_code_t ATT_LEVEL = 4'b1100;

  // State of the persistence stage: how many consecutive samples the
  // candidate code has been seen, and the candidate itself.
  typedef struct packed {
    logic [3:0]     cnt;
    attitude_code_t candidate;
  } persist_state_t;

  // Assemble a code from the per-axis classifier outputs.
  function automatic attitude_code_t pack_code(input logic z_pitch, input logic z_roll,
                                               input logic s_pitch, input logic s_roll);
    attitude_code_t code;
    code                = '0;
    code[ATT_Z_PITCH]   = z_pitch;
    code[ATT_Z_ROLL]    = z_roll;
    code[ATT_SGN_PITCH] = s_pitch;
    code[ATT_SGN_ROLL]  = s_roll;
    return code;
  endfunction

endpackage

// File: rtl/attitude_axis_classifier.sv
// attitude_axis_classifier
//   Classifies one signed axis sample as zero / non-zero with a hysteresis
//   deadband. Two register stages:
//     stage 1: capture sign and saturated magnitude of the sample
//     stage 2: update the zero flag and the output sign bit
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   sample_valid   sample strobe for stage 1
//   stage1_valid   stage-1 contents are a real sample (advances the flag)
//   sample         signed two's complement sample, W bits
//   z              registered zero flag (1 = axis reads as zero)
//   s              registered sign bit, forced to 0 while the axis is zero
module attitude_axis_classifier #(
  parameter int W      = 16,
  parameter int DB_IN  = 64,
  parameter int DB_OUT = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_valid,
  input  logic         stage1_valid,
  input  logic [W-1:0] sample,
  output logic         z,
  output logic         s
);

  localparam logic [W-1:0] DB_IN_W  = W'(DB_IN);
  localparam logic [W-1:0] DB_OUT_W = W'(DB_OUT);

  logic         sign_q;
  logic [W-2:0] mag_q;
  logic [W-1:0] neg_sample;
  logic [W-2:0] mag_d;
  logic [W-1:0] mag_ext;
  logic         z_next;

  // |x| in W-1 bits. The most negative value has no positive twin, so it
  // saturates to the largest magnitude instead of wrapping to zero.
  always_comb begin
    neg_sample = -sample;
    mag_d      = sample[W-2:0];
    if (sample[W-1]) begin
      if (sample[W-2:0] == '0) mag_d = '1;
      else                     mag_d = neg_sample[W-2:0];
    end
  end

  assign mag_ext = {1'b0, mag_q};

  // Hysteresis: enter zero at or below DB_IN, leave zero only above DB_OUT.
  always_comb begin
    if (z) z_next = !(mag_ext > DB_OUT_W);
    else   z_next = (mag_ext <= DB_IN_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      z      <= 1'b1;
      s      <= 1'b0;
    end else begin
      if (sample_valid) begin
        sign_q <= sample[W-1];
        mag_q  <= mag_d;
      end
      if (stage1_valid) begin
        z <= z_next;
        s <= z_next ? 1'b0 : sign_q;
      end
    end
  end

endmodule

// File: rtl/attitude_encoder.sv
// attitude_encoder
//   Classifies roll and pitch samples into a 4-bit attitude code and commits
//   a new code only after it has persisted for PERSIST consecutive samples.
//   Three-stage pipeline: classify (2 stages, per axis) then persistence.
//   Valid-only interface: a sample is taken on every cycle i_Valid is high,
//   there is no backpressure; o_Valid marks each sample leaving the commit
//   stage exactly three cycles later, o_Changed marks the ones that changed
//   o_Attitude.
// Ports
//   i_Clk, i_Rst_n     clock, asynchronous active-low reset
//   i_Valid            sample strobe
//   i_Roll, i_Pitch    signed W-bit samples
//   o_Attitude         committed code {zP, zR, sP, sR}
//   o_Valid            one-cycle pulse per classified sample
//   o_Changed          one-cycle pulse when o_Attitude took a new value
module attitude_encoder
  import attitude_pkg::*;
#(
  parameter int W       = 16,
  parameter int DB_IN   = 64,
  parameter int DB_OUT  = 96,
  parameter int PERSIST = 4
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  input  logic           i_Valid,
  input  logic [W-1:0]   i_Roll,
  input  logic [W-1:0]   i_Pitch,
  output attitude_code_t o_Attitude,
  output logic           o_Valid,
  output logic           o_Changed
);

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  logic           v1;
  logic           v2;
  logic           z_roll;
  logic           s_roll;
  logic           z_pitch;
  logic           s_pitch;
  attitude_code_t raw;
  persist_state_t persist_state;
  logic [3:0]     cnt_inc;

  attitude_axis_classifier #(.W(W), .DB_IN(DB_IN), .DB_OUT(DB_OUT)) u_roll (
    .clk          (i_Clk),
    .rst_n        (i_Rst_n),
    .sample_valid (i_Valid),
    .stage1_valid (v1),
    .sample       (i_Roll),
    .z            (z_roll),
    .s            (s_roll)
  );

  attitude_axis_classifier #(.W(W), .DB_IN(DB_IN), .DB_OUT(DB_OUT)) u_pitch (
    .clk          (i_Clk),
    .rst_n        (i_Rst_n),
    .sample_valid (i_Valid),
    .stage1_valid (v1),
    .sample       (i_Pitch),
    .z            (z_pitch),
    .s            (s_pitch)
  );

  assign raw     = pack_code(z_pitch, z_roll, s_pitch, s_roll);
  // Saturating increment keeps the counter from wrapping back into range.
  assign cnt_inc = (persist_state.cnt == 4'hF) ? 4'hF : persist_state.cnt + 4'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      v1                      <= 1'b0;
      v2                      <= 1'b0;
      o_Valid                 <= 1'b0;
      o_Changed               <= 1'b0;
      o_Attitude              <= ATT_LEVEL;
      persist_state.cnt       <= 4'd0;
      persist_state.candidate <= ATT_LEVEL;
    end else begin
      v1        <= i_Valid;
      v2        <= v1;
      o_Valid   <= v2;
      o_Changed <= 1'b0;
      if (v2) begin
        if (raw == o_Attitude) begin
          persist_state.cnt       <= 4'd0;
          persist_state.candidate <= raw;
        end else if (raw == persist_state.candidate) begin
          if (cnt_inc == PERSIST_C) begin
            o_Attitude        <= raw;
            o_Changed         <= 1'b1;
            persist_state.cnt <= 4'd0;
          end else begin
            persist_state.cnt <= cnt_inc;
          end
        end else begin
          // A different code restarts the run, counting itself as the first.
          persist_state.candidate <= raw;
          if (PERSIST_C == 4'd1) begin
            o_Attitude        <= raw;
            o_Changed         <= 1'b1;
            persist_state.cnt <= 4'd0;
          end else begin
            persist_state.cnt <= 4'd1;
          end
        end
      end
    end
  end

endmodule
